// File: rtl/adjust_ctrl_pkg.sv
// Shared encodings for the alarm-clock front panel: modes, digit fields, button bundle.
package adjust_ctrl_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned FLD_W   = 2;
    localparam int unsigned NUM_FLD = 4;
    localparam int unsigned NUM_BTN = 5;

    // Operating modes (encoding 3 is unused)
    localparam logic [MODE_W-1:0] MODE_CLOCK     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ADJ_TIME  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_ADJ_ALARM = 2'd2;

    // Digit field indices
    localparam logic [FLD_W-1:0] FLD_MIN_U = 2'd0;
    localparam logic [FLD_W-1:0] FLD_MIN_T = 2'd1;
    localparam logic [FLD_W-1:0] FLD_HR_U  = 2'd2;
    localparam logic [FLD_W-1:0] FLD_HR_T  = 2'd3;

    // One bit per front-panel button; MSB first so it packs from a concatenation
    typedef struct packed {
        logic center;
        logic left;
        logic right;
        logic up;
        logic down;
    } btn_t;

    // One-hot select for a digit field
    function automatic logic [NUM_FLD-1:0] fld_onehot(input logic [FLD_W-1:0] fld);
        return NUM_FLD'(1) << fld;
    endfunction

    // Mode sequence driven by the center button; unused encoding falls back to CLOCK
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur);
        logic [MODE_W-1:0] nxt;
        case (cur)
            MODE_CLOCK:     nxt = MODE_ADJ_TIME;
            MODE_ADJ_TIME:  nxt = MODE_ADJ_ALARM;
            default:        nxt = MODE_CLOCK;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/adjust_ctrl_if.sv
// Front-panel bus: raw buttons in, counter enables / mode indicators out.
interface adjust_ctrl_if;
    import adjust_ctrl_pkg::*;

    logic               btn_center;
    logic               btn_left;
    logic               btn_right;
    logic               btn_up;
    logic               btn_down;
    logic [MODE_W-1:0]  mode;
    logic [FLD_W-1:0]   field;
    logic               run;
    logic [NUM_FLD-1:0] time_en;
    logic [NUM_FLD-1:0] alarm_en;
    logic               up_down;
    logic [NUM_FLD-1:0] field_led;

    modport master (
        output btn_center, btn_left, btn_right, btn_up, btn_down,
        input  mode, field, run, time_en, alarm_en, up_down, field_led
    );

    modport slave (
        input  btn_center, btn_left, btn_right, btn_up, btn_down,
        output mode, field, run, time_en, alarm_en, up_down, field_led
    );

endinterface

// File: rtl/adjust_ctrl_btn_cond.sv
// Button conditioner: 2-FF synchronizer, debounce counter, one-cycle press pulse.
module adjust_ctrl_btn_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    // Debounce, release-arming and rising-edge detection
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        cnt_d       = '0;
        level_d     = level_q;
        level_dly_d = level_q;
        // A button held through reset must be seen released before it can fire
        armed_d     = armed_q | (~sync2_q & ~level_q);
        press_d     = level_q & ~level_dly_q & armed_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; synchronizer resets to "pressed" so a held button stays unarmed
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            armed_q     <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            armed_q     <= armed_d;
            press_q     <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/adjust_ctrl.sv
// Alarm-clock front-panel control: button conditioning plus mode/field/adjust FSM.
module adjust_ctrl
    import adjust_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic          clk,
    input  logic          rst,
    adjust_ctrl_if.slave  bus
);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] press_vec;
    btn_t               press;

    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [FLD_W-1:0]   field_q, field_d;
    logic               run_q, run_d;
    logic [NUM_FLD-1:0] time_en_q, time_en_d;
    logic [NUM_FLD-1:0] alarm_en_q, alarm_en_d;
    logic               up_down_q, up_down_d;
    logic [NUM_FLD-1:0] field_led_q, field_led_d;

    assign raw_vec = {bus.btn_center, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
    assign press   = btn_t'(press_vec);

    // One conditioner per button
    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_btn
        adjust_ctrl_btn_cond #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (raw_vec[i]),
            .press   (press_vec[i])
        );
    end

    // Mode/field FSM and next output values
    always_comb begin
        mode_d     = mode_q;
        field_d    = field_q;
        up_down_d  = up_down_q;
        time_en_d  = '0;
        alarm_en_d = '0;
        if (press.center) begin
            mode_d  = next_mode(mode_q);
            field_d = FLD_MIN_U;
        end else if (mode_q == MODE_ADJ_TIME || mode_q == MODE_ADJ_ALARM) begin
            if (press.right && !press.left) begin
                field_d = field_q + FLD_W'(1);
            end else if (press.left && !press.right) begin
                field_d = field_q - FLD_W'(1);
            end
            // Pulse targets the field selected before any move this cycle
            if (press.up != press.down) begin
                up_down_d = press.up;
                if (mode_q == MODE_ADJ_TIME) begin
                    time_en_d = fld_onehot(field_q);
                end else begin
                    alarm_en_d = fld_onehot(field_q);
                end
            end
        end
        run_d       = (mode_d == MODE_CLOCK);
        field_led_d = (mode_d == MODE_CLOCK) ? '0 : fld_onehot(field_d);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= MODE_CLOCK;
            field_q     <= FLD_MIN_U;
            run_q       <= 1'b1;
            time_en_q   <= '0;
            alarm_en_q  <= '0;
            up_down_q   <= 1'b1;
            field_led_q <= '0;
        end else begin
            mode_q      <= mode_d;
            field_q     <= field_d;
            run_q       <= run_d;
            time_en_q   <= time_en_d;
            alarm_en_q  <= alarm_en_d;
            up_down_q   <= up_down_d;
            field_led_q <= field_led_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.field     = field_q;
    assign bus.run       = run_q;
    assign bus.time_en   = time_en_q;
    assign bus.alarm_en  = alarm_en_q;
    assign bus.up_down   = up_down_q;
    assign bus.field_led = field_led_q;

endmodule

// File: doc/adjust_ctrl.md
# adjust_ctrl

Front-panel control stage for the alarm clock: conditions five raw pushbuttons and drives the enable and direction inputs of the digit counters (minute-units, minute-tens, hour-units, hour-tens) for both the time-of-day and the alarm registers. It sits directly upstream of the modulo counter wrappers. It decides when they count freely, which one is being adjusted, and in which direction.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a button level is accepted (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- btn_center, btn_left, btn_right, btn_up, btn_down  in  1 each  raw asynchronous buttons, active-high
- mode  out  2  current mode: 0 CLOCK, 1 ADJ_TIME, 2 ADJ_ALARM (3 unused)
- field  out  2  selected digit: 0 min-units, 1 min-tens, 2 hr-units, 3 hr-tens
- run  out  1  high only in CLOCK; gates normal time counting
- time_en  out  4  one-hot single-cycle adjust pulse to time counters, bit = field
- alarm_en  out  4  one-hot single-cycle adjust pulse to alarm counters, bit = field
- up_down  out  1  direction for the pulsed counter: 1 up, 0 down
- field_led  out  4  one-hot of field in adjust modes, 0 in CLOCK

## Operation
- Reset (rst low at an edge): mode=CLOCK, field=0, run=1, time_en=0, alarm_en=0, up_down=1, field_led=0; all debounce counters and levels cleared, so a button held through reset yields no pulse until it is released and pressed again.
- Each button goes through its own conditioner:
  - 2-FF synchronizer.
  - Debounce counter, width $clog2(DEBOUNCE_CYCLES+1). It increments while the synced value ≠ the accepted level and clears whenever they are equal.
  - On reaching DEBOUNCE_CYCLES the level flips and the counter clears.
  - A rising edge of the accepted level gives a one-cycle press pulse. Releases give no pulse.
- FSM on press pulses, evaluated per cycle in priority order:
  - center: CLOCK→ADJ_TIME→ADJ_ALARM→CLOCK; field reset to 0 on every mode change. All other presses in the same cycle are dropped.
  - left/right (adjust modes only): field −1 / +1 modulo 4 (3→0 on right, 0→3 on left). Both in the same cycle: no move.
  - up/down (adjust modes only): up_down←1/0 and a one-cycle pulse on bit[field] of time_en (ADJ_TIME) or alarm_en (ADJ_ALARM). Both in the same cycle: no pulse, up_down unchanged.
  - left/right and up/down in the same cycle: both act. The pulse uses the field value before the move.
- In CLOCK, left/right/up/down are ignored; time_en=alarm_en=0.
- up_down holds its last value between pulses.
- time_en and alarm_en are never both nonzero and are never multi-hot.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Raw button high and stable from before edge k: accepted level high after edge k+DEBOUNCE_CYCLES+1, press pulse after k+DEBOUNCE_CYCLES+2, FSM outputs updated after k+DEBOUNCE_CYCLES+3.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no pulse and resets the count.
- Enable pulses last exactly one clk cycle. Downstream counters sampling on clk see exactly one step per press.
- rst low mid-pulse clears the pulse on that edge. Reset has priority over every input.
- run changes on the same edge as mode.

## Structure
- Shared package:
  - mode encodings MODE_CLOCK/MODE_ADJ_TIME/MODE_ADJ_ALARM.
  - field indices FLD_MIN_U/FLD_MIN_T/FLD_HR_U/FLD_HR_T.
  - Used also by the display mux and the alarm comparator.
- One sub-module, btn_cond (synchronizer + debounce + rise pulse, parameter DEBOUNCE_CYCLES), instantiated five times.
- FSM and output registers live in adjust_ctrl.

## Test plan
- Use DEBOUNCE_CYCLES=4 throughout.
- Reset: hold btn_up high through and after rst release → no pulse on any output; outputs equal reset values; the pulse appears only after release plus a new press.
- Debounce: center high for 3 synced cycles then low → mode stays 0. Center high 10 cycles → mode=1 exactly DEBOUNCE_CYCLES+3 edges after the rise; field=0; run=0; field_led=4'b0001.
- Field wrap: in ADJ_TIME, press left once → field=3, field_led=4'b1000. Press right → field=0.
- Adjust pulses: ADJ_TIME field=2, press up → time_en=4'b0100 for one cycle, up_down=1. Press down → same bit pulses with up_down=0. alarm_en stays 0.
- Simultaneity:
  - up+down together → no pulse, up_down unchanged.
  - center+up together in ADJ_TIME → mode=2, field=0, no pulse.
  - right+up in ADJ_ALARM at field=1 → alarm_en=4'b0010, field becomes 2.
- Mode cycle: three center presses → mode 1, 2, 0. In CLOCK, up/left presses → no output change and run=1.
